// File: rtl/lcd_text_feeder.sv
// UART-to-HD44780 text feeder: byte FIFO, 2x16 cursor tracking, and a single
// outstanding req/ack write to the LCD controller (characters, line jumps, clear).
module lcd_text_feeder #(
    parameter int         FIFO_DEPTH = 16,
    parameter int         COLS       = 16,
    parameter logic [7:0] LINE1_CMD  = 8'h80,
    parameter logic [7:0] LINE2_CMD  = 8'hC0,
    parameter logic [7:0] CLR_CMD    = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       lcd_req,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    input  logic       lcd_ack,
    output logic       fifo_ovf,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(COLS + 1);

    typedef enum logic [2:0] {IDLE, FETCH, CLASSIFY, CHAR_REQ, CMD_REQ} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [7:0]    byte_q;
    logic          row, row_n;
    logic [CW-1:0] col, col_n;
    logic          req_n, rs_n;
    logic [7:0]    data_n;
    logic          full, empty, push, pop;

    // Full is judged on registered pointers, so a same-cycle pop never frees room.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = rx_valid && !full;
    assign pop   = (state == IDLE) && !empty;

    assign wr_ptr_n = wr_ptr + (AW+1)'(push);
    assign rd_ptr_n = rd_ptr + (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
    end

    always_comb begin
        state_n = state;
        req_n   = lcd_req;
        rs_n    = lcd_rs;
        data_n  = lcd_data;
        row_n   = row;
        col_n   = col;
        case (state)
            IDLE:     if (!empty) state_n = FETCH;
            FETCH:    state_n = CLASSIFY;
            CLASSIFY: begin
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    state_n = CHAR_REQ;
                    req_n   = 1'b1;
                    rs_n    = 1'b1;
                    data_n  = byte_q;
                end else if (byte_q == 8'h0D) begin
                    state_n = CMD_REQ;
                    req_n   = 1'b1;
                    rs_n    = 1'b0;
                    data_n  = row ? LINE1_CMD : LINE2_CMD;
                    row_n   = ~row;
                    col_n   = '0;
                end else if (byte_q == 8'h0C) begin
                    state_n = CMD_REQ;
                    req_n   = 1'b1;
                    rs_n    = 1'b0;
                    data_n  = CLR_CMD;
                    row_n   = 1'b0;
                    col_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            CHAR_REQ: begin
                if (lcd_ack) begin
                    req_n = 1'b0;
                    if (col == CW'(COLS - 1)) begin
                        // Line wrap: the address command goes out after one idle req cycle.
                        col_n   = '0;
                        row_n   = ~row;
                        rs_n    = 1'b0;
                        data_n  = row ? LINE1_CMD : LINE2_CMD;
                        state_n = CMD_REQ;
                    end else begin
                        col_n   = col + 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            CMD_REQ: begin
                if (lcd_req && lcd_ack) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end else if (!lcd_req) begin
                    req_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_q   <= '0;
            row      <= 1'b0;
            col      <= '0;
            lcd_req  <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
            fifo_ovf <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            if (pop) byte_q <= mem[rd_ptr[AW-1:0]];
            row      <= row_n;
            col      <= col_n;
            lcd_req  <= req_n;
            lcd_rs   <= rs_n;
            lcd_data <= data_n;
            fifo_ovf <= rx_valid && full;
            busy     <= (wr_ptr_n != rd_ptr_n) || (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed bench for lcd_text_feeder: a handshake-only lcd_ctrl stand-in driven
// from one linear initial block, with expected bytes written by hand.
module tb_lcd_text_feeder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       lcd_req, lcd_rs, lcd_ack = 1'b0;
    logic [7:0] lcd_data;
    logic       fifo_ovf, busy;

    int n_cmp = 0;
    int n_err = 0;

    lcd_text_feeder dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .lcd_req(lcd_req), .lcd_rs(lcd_rs), .lcd_data(lcd_data), .lcd_ack(lcd_ack),
        .fifo_ovf(fifo_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait for a request, check it, hold for 'hold' cycles, then ack once.
    task automatic expect_req(input string tag, input logic rs, input logic [7:0] data, input int hold);
        int t = 0;
        while (!lcd_req && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s.req", tag), lcd_req, 1);
        if (lcd_req) begin
            chk($sformatf("%s.rs", tag), lcd_rs, rs);
            chk($sformatf("%s.data", tag), lcd_data, data);
            if (hold > 1) begin
                repeat (hold - 1) @(negedge clk);
                chk($sformatf("%s.held", tag), {lcd_req, lcd_rs, lcd_data}, {1'b1, rs, data});
            end
            lcd_ack = 1'b1;
            @(negedge clk);
            lcd_ack = 1'b0;
            chk($sformatf("%s.drop", tag), lcd_req, 0);
        end
    endtask

    task automatic put_line(input logic [7:0] base, input logic [7:0] cmd);
        for (int i = 0; i < 16; i++) begin
            send_byte(base + 8'(i));
            expect_req("line_chr", 1'b1, base + 8'(i), 1);
        end
        expect_req("line_cmd", 1'b0, cmd, 1);
    endtask

    initial begin
        logic seen;
        #12;
        chk("rst_req", lcd_req, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_ovf", fifo_ovf, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single char: 3-cycle latency, request held 5 cycles
        send_byte(8'h41);
        chk("lat0", lcd_req, 0);
        @(negedge clk); chk("lat1", lcd_req, 0);
        @(negedge clk); chk("lat2", lcd_req, 0);
        @(negedge clk); chk("lat3", lcd_req, 1);
        chk("busy_req", busy, 1);
        expect_req("A", 1'b1, 8'h41, 5);
        chk("busy_done", busy, 0);

        // Cursor at col 1: H, CR (row0 -> 0xC0), i, FF -> clear
        send_byte(8'h48); expect_req("H", 1'b1, 8'h48, 1);
        send_byte(8'h0D); expect_req("CR", 1'b0, 8'hC0, 1);
        send_byte(8'h69); expect_req("i", 1'b1, 8'h69, 2);
        send_byte(8'h0C); expect_req("FF", 1'b0, 8'h01, 1);

        // 17 queued chars: 16 writes, line-2 address, then the 17th char
        for (int i = 0; i < 17; i++) send_byte(8'h30 + 8'(i));
        for (int i = 0; i < 16; i++) expect_req("q_chr", 1'b1, 8'h30 + 8'(i), 1);
        expect_req("q_wrap", 1'b0, 8'hC0, 1);
        expect_req("q_17th", 1'b1, 8'h40, 1);
        send_byte(8'h0C); expect_req("FF2", 1'b0, 8'h01, 1);

        // 32 chars wrap back to line 1; the next line proves row=0, col=0
        put_line(8'h41, 8'hC0);
        put_line(8'h61, 8'h80);
        put_line(8'h30, 8'hC0);

        // Overflow: hold one request, then push 17 bytes into the 16-entry FIFO
        send_byte(8'h58);
        repeat (3) @(negedge clk);
        chk("ovf_hold_req", lcd_req, 1);
        for (int i = 0; i < 17; i++) begin
            rx_data  = 8'h50 + 8'(i);
            rx_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("ovf_%0d", i), fifo_ovf, (i == 16));
        end
        rx_valid = 1'b0;
        @(negedge clk);
        chk("ovf_pulse_end", fifo_ovf, 0);
        chk("ovf_still_req", lcd_req, 1);

        // Reset mid-transaction drops req at once, nothing stale afterwards
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", lcd_req, 0);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (lcd_req) seen = 1'b1;
        end
        chk("no_stale", seen, 0);

        // Non-printable, non-control byte is silently dropped
        send_byte(8'h07);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (lcd_req) seen = 1'b1;
        end
        chk("bel_no_traffic", seen, 0);
        chk("bel_busy", busy, 0);
        send_byte(8'h51); expect_req("Q", 1'b1, 8'h51, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
